// File: rtl/biu_prefetch_queue_pkg.sv
// Shared BIU address types and the segment:offset physical address helper.
package biu_prefetch_queue_pkg;

  localparam int PHYS_AW = 20;
  localparam int SEG_W   = 16;
  localparam int BYTE_W  = 8;
  localparam int CNT_W   = 4;

  typedef logic [PHYS_AW-1:0] phys_addr_t;
  typedef logic [SEG_W-1:0]   seg_t;

  // seg*16 + off, truncated to 20 bits (FFFF:0010 wraps to 00000).
  function automatic phys_addr_t phys_addr(input seg_t seg, input seg_t off);
    phys_addr_t s;
    phys_addr_t o;
    s = {seg, 4'h0};
    o = {4'h0, off};
    return s + o;
  endfunction

endpackage

// File: rtl/biu_prefetch_queue_if.sv
// Memory read port and decoder-side queue port of the prefetch queue.
interface biu_prefetch_queue_if;
  import biu_prefetch_queue_pkg::*;

  logic              mem_req;
  phys_addr_t        mem_addr;
  logic              mem_ack;
  logic [BYTE_W-1:0] mem_data;
  logic              q_valid;
  logic [BYTE_W-1:0] q_byte;
  logic              q_pop;
  logic [CNT_W-1:0]  q_count;

  modport master (
    output mem_req, mem_addr, q_valid, q_byte, q_count,
    input  mem_ack, mem_data, q_pop
  );

  modport slave (
    input  mem_req, mem_addr, q_valid, q_byte, q_count,
    output mem_ack, mem_data, q_pop
  );

endinterface

// File: rtl/biu_prefetch_queue_fifo.sv
// DEPTH x 8 first-word-fall-through byte FIFO with occupancy count and sync clear.
module biu_prefetch_queue_fifo
  import biu_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] din_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [BYTE_W-1:0] dout_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic              pop_ok;
  logic              push_ok;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign pop_ok  = pop_i && valid_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (pop_ok)  rd_d = bump(rd_q);
      if (push_ok) wr_d = bump(wr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/biu_prefetch_queue.sv
// Instruction prefetch queue: forms CS:IP byte addresses, fetches one byte at a time, buffers for decode.
// Optional feature macro PFQ_FETCH_CNT_EN adds fetch_cnt_o, a count of accepted fetch bytes.
module biu_prefetch_queue
  import biu_prefetch_queue_pkg::*;
#(
  parameter int         DEPTH    = 6,
  parameter logic [15:0] RESET_IP = 16'hFFF0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  seg_t        cs_i,
  input  logic        flush_i,
  input  seg_t        ip_i,
  output seg_t        fetch_ip_o,
`ifdef PFQ_FETCH_CNT_EN
  output logic [15:0] fetch_cnt_o,
`endif
  biu_prefetch_queue_if.master bus
);

  // state | meaning
  // IDLE  | no request; issue one next cycle if queue has room and no flush
  // REQ   | mem_req high, mem_addr held until mem_ack
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0] state_q, state_d;
  phys_addr_t addr_q, addr_d;
  seg_t       ip_q, ip_d;
  logic       push;
  logic       full;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ip_d    = ip_q;
    push    = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      ip_d    = ip_i;
    end else begin
      case (state_q)
        IDLE: begin
          if (!full) begin
            addr_d  = phys_addr(cs_i, ip_q);
            state_d = REQ;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            push    = 1'b1;
            ip_d    = ip_q + 16'd1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ip_q    <= RESET_IP;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ip_q    <= ip_d;
    end
  end

  assign bus.mem_req  = (state_q == REQ);
  assign bus.mem_addr = addr_q;
  assign fetch_ip_o   = ip_q;

  biu_prefetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (flush_i),
    .push_i  (push),
    .din_i   (bus.mem_data),
    .pop_i   (bus.q_pop & ~flush_i),
    .valid_o (bus.q_valid),
    .dout_o  (bus.q_byte),
    .count_o (bus.q_count),
    .full_o  (full)
  );

`ifdef PFQ_FETCH_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Survives flush; only reset clears it.
  assign fcnt_d = push ? fcnt_q + 16'd1 : fcnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  end

  assign fetch_cnt_o = fcnt_q;
`endif

endmodule
